// File: rtl/cp_bus_frontend_pkg.sv
// Shared types and default constants for the Amiga clock-port front end.
package cp_bus_frontend_pkg;

    localparam int CP_A_W = 4;
    localparam int CP_D_W = 4;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_CYCLES  = 3;
    localparam int DEF_WR_DATA_DELAY  = 4;
    localparam int DEF_RECOVER_CYCLES = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        RD_ACTIVE,
        WR_ACTIVE,
        RECOVER
    } state_t;

endpackage

// File: rtl/cp_bus_frontend_if.sv
// Clock-port pin bundle plus the event/data bundle toward the clock-port logic.
interface cp_bus_frontend_if;
    import cp_bus_frontend_pkg::*;

    logic              cp_rd_n;
    logic              cp_wr_n;
    logic [CP_A_W-1:0] cp_a;
    logic [CP_D_W-1:0] cp_d_in;
    logic [CP_D_W-1:0] cp_d_out;
    logic              cp_d_oe;
    logic [CP_A_W-1:0] address;
    logic              read_start;
    logic [CP_D_W-1:0] read_data;
    logic              read_end;
    logic              write_commit;
    logic [CP_D_W-1:0] write_data;
    logic              clear_status;
    logic              conflict;
    logic              timeout;

    modport slave (
        input  cp_rd_n, cp_wr_n, cp_a, cp_d_in, read_data, clear_status,
        output cp_d_out, cp_d_oe, address, read_start, read_end,
               write_commit, write_data, conflict, timeout
    );

    modport master (
        output cp_rd_n, cp_wr_n, cp_a, cp_d_in, read_data, clear_status,
        input  cp_d_out, cp_d_oe, address, read_start, read_end,
               write_commit, write_data, conflict, timeout
    );

endinterface

// File: rtl/cp_bus_frontend_strobe_filter.sv
// Synchroniser plus stable-count deglitcher for one active-low pin strobe.
module strobe_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk200,
    input  logic reset,
    input  logic strobe_n,
    output logic level
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_p[SYNC_STAGES-1];

    always_ff @(posedge clk200) begin
        if (reset) begin
            sync_p <= '1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], strobe_n};
            // Level flips only after FILTER_CYCLES consecutive differing samples.
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                level <= synced;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp_bus_frontend.sv
// Clock-port front end: deglitched strobes, access FSM, event pulses and fault flags.
module cp_bus_frontend
    import cp_bus_frontend_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
    parameter int WR_DATA_DELAY  = DEF_WR_DATA_DELAY,
    parameter int RECOVER_CYCLES = DEF_RECOVER_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic         clk200,
    input logic         reset,
    cp_bus_frontend_if.slave bus
);
    // Commit lands WR_DATA_DELAY cycles after the filtered fall; one of those is spent in IDLE.
    localparam int WR_LAST = (WR_DATA_DELAY > 2) ? WR_DATA_DELAY - 2 : 0;
    localparam int WR_CW   = $clog2(WR_DATA_DELAY + 1);
    localparam int RC_CW   = $clog2(RECOVER_CYCLES + 1);
    localparam int TO_CW   = $clog2(TIMEOUT_CYCLES + 1);
    // A strobe held low through reset needs this long to show up on the filtered level.
    localparam int GUARD   = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int ID_CW   = $clog2(GUARD + 1);

    logic rd_lvl, wr_lvl;
    logic [SYNC_STAGES-1:0][CP_A_W-1:0] a_sync_p;
    logic [SYNC_STAGES-1:0][CP_D_W-1:0] d_sync_p;

    state_t            state;
    logic [CP_A_W-1:0] address;
    logic [CP_D_W-1:0] write_data, cp_d_out;
    logic              cp_d_oe, read_start, read_end, write_commit;
    logic              conflict, timeout, committed, abort;
    logic [WR_CW-1:0]  wr_cnt;
    logic [RC_CW-1:0]  rec_cnt;
    logic [TO_CW-1:0]  to_cnt;
    logic [ID_CW-1:0]  idle_cnt;
    logic              to_hit, to_sat;

    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_rd_filter (
        .clk200(clk200), .reset(reset), .strobe_n(bus.cp_rd_n), .level(rd_lvl)
    );
    strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_wr_filter (
        .clk200(clk200), .reset(reset), .strobe_n(bus.cp_wr_n), .level(wr_lvl)
    );

    always_ff @(posedge clk200) begin
        if (reset) begin
            a_sync_p <= '0;
            d_sync_p <= '0;
        end else begin
            a_sync_p <= {a_sync_p[SYNC_STAGES-2:0], bus.cp_a};
            d_sync_p <= {d_sync_p[SYNC_STAGES-2:0], bus.cp_d_in};
        end
    end

    assign to_hit = (to_cnt >= TO_CW'(TIMEOUT_CYCLES - 1));
    assign to_sat = (to_cnt == TO_CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk200) begin
        if (reset) begin
            state        <= WAIT_IDLE;
            address      <= '0;
            write_data   <= '0;
            cp_d_out     <= '0;
            cp_d_oe      <= 1'b0;
            read_start   <= 1'b0;
            read_end     <= 1'b0;
            write_commit <= 1'b0;
            conflict     <= 1'b0;
            timeout      <= 1'b0;
            committed    <= 1'b0;
            abort        <= 1'b0;
            wr_cnt       <= '0;
            rec_cnt      <= '0;
            to_cnt       <= '0;
            idle_cnt     <= '0;
        end else begin
            read_start   <= 1'b0;
            read_end     <= 1'b0;
            write_commit <= 1'b0;
            // Any flag set later in this block overrides the clear.
            if (bus.clear_status) begin
                conflict <= 1'b0;
                timeout  <= 1'b0;
            end
            case (state)
                WAIT_IDLE: begin
                    if (!(rd_lvl && wr_lvl))             idle_cnt <= '0;
                    else if (idle_cnt == ID_CW'(GUARD))  state    <= IDLE;
                    else                                 idle_cnt <= idle_cnt + 1'b1;
                end
                IDLE: begin
                    wr_cnt    <= '0;
                    to_cnt    <= '0;
                    committed <= 1'b0;
                    abort     <= 1'b0;
                    idle_cnt  <= '0;
                    if (!rd_lvl && !wr_lvl) begin
                        conflict <= 1'b1;
                        state    <= WAIT_IDLE;
                    end else if (!rd_lvl) begin
                        address    <= a_sync_p[SYNC_STAGES-1];
                        read_start <= 1'b1;
                        state      <= RD_ACTIVE;
                    end else if (!wr_lvl) begin
                        address <= a_sync_p[SYNC_STAGES-1];
                        state   <= WR_ACTIVE;
                    end
                end
                RD_ACTIVE: begin
                    cp_d_out <= bus.read_data;
                    if (!to_sat) to_cnt  <= to_cnt + 1'b1;
                    if (to_hit)  timeout <= 1'b1;
                    if (!wr_lvl) begin
                        conflict <= 1'b1;
                        abort    <= 1'b1;
                    end
                    if (rd_lvl) begin
                        cp_d_oe  <= 1'b0;
                        read_end <= 1'b1;
                        rec_cnt  <= '0;
                        state    <= (abort || !wr_lvl) ? WAIT_IDLE : RECOVER;
                    end else begin
                        cp_d_oe <= !to_hit;
                    end
                end
                WR_ACTIVE: begin
                    if (!to_sat) to_cnt  <= to_cnt + 1'b1;
                    if (to_hit)  timeout <= 1'b1;
                    if (!rd_lvl) begin
                        conflict <= 1'b1;
                        abort    <= 1'b1;
                    end
                    if (wr_lvl) begin
                        if (!committed) begin
                            write_data   <= d_sync_p[SYNC_STAGES-1];
                            write_commit <= 1'b1;
                        end
                        rec_cnt <= '0;
                        state   <= (abort || !rd_lvl) ? WAIT_IDLE : RECOVER;
                    end else if (!committed && wr_cnt >= WR_CW'(WR_LAST)) begin
                        write_data   <= d_sync_p[SYNC_STAGES-1];
                        write_commit <= 1'b1;
                        committed    <= 1'b1;
                    end else if (!committed) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    if (rec_cnt == RC_CW'(RECOVER_CYCLES - 1)) state   <= IDLE;
                    else                                       rec_cnt <= rec_cnt + 1'b1;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end

    assign bus.address      = address;
    assign bus.write_data   = write_data;
    assign bus.cp_d_out     = cp_d_out;
    assign bus.cp_d_oe      = cp_d_oe;
    assign bus.read_start   = read_start;
    assign bus.read_end     = read_end;
    assign bus.write_commit = write_commit;
    assign bus.conflict     = conflict;
    assign bus.timeout      = timeout;

endmodule

// File: tb/tb_cp_bus_frontend.sv
// Directed bench for cp_bus_frontend; edge 0 is the first clock edge sampling a new pin level.
module tb_cp_bus_frontend;
    import cp_bus_frontend_pkg::*;

    logic       clk200 = 1'b0;
    logic       reset = 1'b1;
    logic       rd_n = 1'b1, wr_n = 1'b1, clear_status = 1'b0;
    logic [3:0] cp_a = '0, cp_d_in = '0, read_data = '0;
    int         tests = 0, failures = 0;

    cp_bus_frontend_if bus();
    cp_bus_frontend_if bus_slow();

    assign bus.cp_rd_n = rd_n;           assign bus_slow.cp_rd_n = rd_n;
    assign bus.cp_wr_n = wr_n;           assign bus_slow.cp_wr_n = wr_n;
    assign bus.cp_a = cp_a;              assign bus_slow.cp_a = cp_a;
    assign bus.cp_d_in = cp_d_in;        assign bus_slow.cp_d_in = cp_d_in;
    assign bus.read_data = read_data;    assign bus_slow.read_data = read_data;
    assign bus.clear_status = clear_status;
    assign bus_slow.clear_status = clear_status;

    cp_bus_frontend dut (.clk200(clk200), .reset(reset), .bus(bus));
    cp_bus_frontend #(.WR_DATA_DELAY(16)) dut_slow (.clk200(clk200), .reset(reset), .bus(bus_slow));

    always #5 clk200 = ~clk200;

    typedef struct {
        int         rd_len;
        int         wr_start;
        int         wr_len;
        logic [3:0] a;
        logic [3:0] d;
        logic [3:0] rdata;
        int         e_start;
        int         e_end;
        int         e_commit;
        int         e_commit_slow;
        logic [3:0] e_wdata;
        logic       e_conflict;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk200);
        @(negedge clk200);
    endtask

    task automatic clear_pulse();
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        step();
    endtask

    function automatic int all_out(input int slow);
        if (slow != 0)
            return int'({bus_slow.cp_d_out, bus_slow.cp_d_oe, bus_slow.address, bus_slow.read_start,
                         bus_slow.read_end, bus_slow.write_commit, bus_slow.write_data,
                         bus_slow.conflict, bus_slow.timeout});
        return int'({bus.cp_d_out, bus.cp_d_oe, bus.address, bus.read_start, bus.read_end,
                     bus.write_commit, bus.write_data, bus.conflict, bus.timeout});
    endfunction

    vec_t       vt[8];
    int         win, n_st, e_st, n_en, e_en, n_cm, e_cm, n_cs, e_cs, oe_err;
    logic [3:0] a_st, a_cm, wd, wd_s;
    logic       exp_oe;

    initial begin
        vt[0] = '{40, 0, 0,  4'hA, 4'h0, 4'h5,  5, 45, -1, -1, 4'h0, 1'b0};
        vt[1] = '{0,  0, 30, 4'h3, 4'hC, 4'h0, -1, -1,  8, 20, 4'hC, 1'b0};
        vt[2] = '{0,  0, 6,  4'h5, 4'h9, 4'h0, -1, -1,  8, 11, 4'h9, 1'b0};
        vt[3] = '{0,  0, 3,  4'hE, 4'h2, 4'h0, -1, -1,  8,  8, 4'h2, 1'b0};
        vt[4] = '{2,  0, 0,  4'h1, 4'h0, 4'h3, -1, -1, -1, -1, 4'h0, 1'b0};
        vt[5] = '{10, 0, 0,  4'h6, 4'h0, 4'h9,  5, 15, -1, -1, 4'h0, 1'b0};
        vt[6] = '{20, 0, 20, 4'hF, 4'hF, 4'hF, -1, -1, -1, -1, 4'h0, 1'b1};
        vt[7] = '{30, 10, 10, 4'h2, 4'h4, 4'h8, 5, 35, -1, -1, 4'h0, 1'b1};

        @(negedge clk200);
        step(); step(); step();
        check("reset_outputs", all_out(0), 0);
        check("reset_outputs_slow", all_out(1), 0);
        reset = 1'b0;
        repeat (20) step();
        check("idle_outputs", all_out(0), 0);

        for (int v = 0; v < 8; v++) begin
            cp_a = vt[v].a; cp_d_in = vt[v].d; read_data = vt[v].rdata;
            win = ((vt[v].rd_len > vt[v].wr_start + vt[v].wr_len) ? vt[v].rd_len
                   : vt[v].wr_start + vt[v].wr_len) + 20;
            n_st = 0; e_st = -1; n_en = 0; e_en = -1; n_cm = 0; e_cm = -1; n_cs = 0; e_cs = -1;
            oe_err = 0; a_st = '0; a_cm = '0; wd = '0; wd_s = '0;
            for (int i = 0; i < win; i++) begin
                rd_n = !(i < vt[v].rd_len);
                wr_n = !(i >= vt[v].wr_start && i < vt[v].wr_start + vt[v].wr_len);
                step();
                if (bus.read_start) begin n_st++; if (n_st == 1) begin e_st = i; a_st = bus.address; end end
                if (bus.read_end) begin n_en++; if (n_en == 1) e_en = i; end
                if (bus.write_commit) begin
                    n_cm++;
                    if (n_cm == 1) begin e_cm = i; wd = bus.write_data; a_cm = bus.address; end
                end
                if (bus_slow.write_commit) begin
                    n_cs++;
                    if (n_cs == 1) begin e_cs = i; wd_s = bus_slow.write_data; end
                end
                exp_oe = (vt[v].e_start >= 0 && i > vt[v].e_start && i < vt[v].e_end);
                if (bus.cp_d_oe !== exp_oe || (exp_oe && bus.cp_d_out !== vt[v].rdata)) oe_err++;
            end
            check($sformatf("v%0d_start_count", v), n_st, (vt[v].e_start >= 0) ? 1 : 0);
            check($sformatf("v%0d_end_count", v), n_en, (vt[v].e_end >= 0) ? 1 : 0);
            check($sformatf("v%0d_commit_count", v), n_cm, (vt[v].e_commit >= 0) ? 1 : 0);
            check($sformatf("v%0d_commit_count_slow", v), n_cs, (vt[v].e_commit_slow >= 0) ? 1 : 0);
            check($sformatf("v%0d_oe_dout_errors", v), oe_err, 0);
            check($sformatf("v%0d_conflict", v), bus.conflict, vt[v].e_conflict);
            check($sformatf("v%0d_timeout", v), bus.timeout, 0);
            if (vt[v].e_start >= 0) begin
                check($sformatf("v%0d_start_edge", v), e_st, vt[v].e_start);
                check($sformatf("v%0d_start_addr", v), a_st, vt[v].a);
                check($sformatf("v%0d_end_edge", v), e_en, vt[v].e_end);
            end
            if (vt[v].e_commit >= 0) begin
                check($sformatf("v%0d_commit_edge", v), e_cm, vt[v].e_commit);
                check($sformatf("v%0d_commit_data", v), wd, vt[v].e_wdata);
                check($sformatf("v%0d_commit_addr", v), a_cm, vt[v].a);
                check($sformatf("v%0d_commit_edge_slow", v), e_cs, vt[v].e_commit_slow);
                check($sformatf("v%0d_commit_data_slow", v), wd_s, vt[v].e_wdata);
            end
            clear_pulse();
            check($sformatf("v%0d_conflict_cleared", v), bus.conflict, 0);
            repeat (10) step();
        end

        // Read strobe held far past the timeout limit.
        cp_a = 4'h9; read_data = 4'h7;
        n_en = 0; e_en = -1; oe_err = 0;
        for (int i = 0; i < 1120; i++) begin
            rd_n = !(i < 1100);
            step();
            if (i == 1027) begin
                check("to_flag_before", bus.timeout, 0);
                check("to_oe_before", bus.cp_d_oe, 1);
            end
            if (i == 1028) begin
                check("to_flag_at_limit", bus.timeout, 1);
                check("to_oe_at_limit", bus.cp_d_oe, 0);
            end
            if (i >= 1028 && bus.cp_d_oe) oe_err++;
            if (bus.read_end) begin n_en++; if (n_en == 1) e_en = i; end
        end
        check("to_oe_stays_low", oe_err, 0);
        check("to_read_end_count", n_en, 1);
        check("to_read_end_edge", e_en, 1105);
        check("to_flag_sticky", bus.timeout, 1);
        clear_pulse();
        check("to_flag_cleared", bus.timeout, 0);
        repeat (10) step();

        // Reset lands mid-read while the strobe stays low.
        cp_a = 4'h4; read_data = 4'hB;
        n_st = 0; e_st = -1;
        for (int i = 0; i < 100; i++) begin
            rd_n = !((i < 60) || (i >= 80));
            reset = (i == 20 || i == 21);
            step();
            if (i == 19) check("rst_mid_oe_active", bus.cp_d_oe, 1);
            if (i == 20) check("rst_mid_outputs", all_out(0), 0);
            if (i >= 20 && bus.read_start) begin n_st++; if (n_st == 1) e_st = i; end
        end
        check("rst_restart_count", n_st, 1);
        check("rst_restart_edge", e_st, 85);
        rd_n = 1'b1;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
